dcache_ctrl: RTL
================

DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL provide reset  input  1  synchronous active-high reset.
REQ-003 SHALL provide addr  input  32  core MEM-stage byte address.
REQ-004 SHALL provide wdata  input  32  core store data, right-aligned.
REQ-005 SHALL provide mem_read / mem_write  input  1 each  core load / store request.
REQ-006 SHALL provide mask  input  3  RISC-V funct3 size code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL provide rdata  output  32  load result, extended per mask.
REQ-008 SHALL provide hit  output  1  current load request hits.
REQ-009 SHALL provide stall  output  1  core must hold its pipeline this cycle.
REQ-010 SHALL provide mem_req_valid output 1, mem_req_ready input 1, mem_req_we output 1, mem_req_addr output 32, mem_req_wdata output 32, mem_req_wstrb output 4: backing-memory request channel.
REQ-011 SHALL provide mem_resp_valid input 1, mem_resp_rdata input 32: backing-memory read-response channel.

Function
REQ-012 SHALL be direct-mapped: 16 one-word lines; index addr[5:2], tag addr[31:6], one valid bit per line.
REQ-013 SHALL be write-through, no-write-allocate.
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-015 IDLE, load hit: rdata and hit=1 combinational in the same cycle, stall=0, zero added latency.
REQ-016 IDLE, load miss: stall=1 same cycle; next state RD_REQ.
REQ-017 RD_REQ: mem_req_valid=1, we=0, addr word-aligned; on mem_req_ready go to RD_WAIT.
REQ-018 RD_WAIT: on mem_resp_valid write line data, tag and valid=1, go to IDLE; the retried load then hits.
REQ-019 IDLE, store: stall=1; next state WR_REQ.
REQ-020 WR_REQ: mem_req_valid=1, we=1, wdata byte/halfword replicated onto lanes, wstrb from mask and addr[1:0]; on mem_req_ready update hit line's strobed bytes and go to IDLE with stall=0 that cycle.
REQ-021 stall SHALL be 1 in every non-IDLE state, except the completing cycle of REQ-020.
REQ-022 mem_req_* SHALL remain stable while mem_req_valid=1 and mem_req_ready=0.
REQ-023 Simultaneous mem_read and mem_write SHALL be serviced as a store.
REQ-024 Load extraction: byte lane addr[1:0], halfword lane addr[1], word ignores addr[1:0]; BU/HU zero-extend, B/H sign-extend.
REQ-025 mem_resp_valid outside RD_WAIT SHALL be ignored.
REQ-026 hit SHALL be 0 when mem_read=0.

Reset
REQ-027 Reset SHALL force IDLE and clear all valid bits; line data/tag SHALL not be cleared.
REQ-028 During reset, rdata=0, hit=0, stall=0, mem_req_valid=0.
REQ-029 Reset mid-transaction SHALL abandon it; mem_req_valid=0 from the cycle after reset is sampled.

Configuration
REQ-030 Macro DCACHE_STATS_EN defined: SHALL add outputs stat_hits and stat_misses, 32 bits each, counting IDLE load hits and misses; counters wrap at 2^32 and clear on reset.
REQ-031 Macro DCACHE_STATS_EN undefined: counters and ports SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package dcache_pkg SHALL hold the FSM state enum, the mask funct3 codes, and constants for line count, index width and tag width.
REQ-033 Sub-module dcache_load_align SHALL perform the combinational lane select and extension of REQ-024.

Verification
REQ-034 Reset, LW 0x100 -> stall=1, RD_REQ addr 0x100; response 0xDEADBEEF -> retry hit=1, rdata=0xDEADBEEF, stall=0.
REQ-035 After REQ-034, LB 0x103 -> rdata=0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD.
REQ-036 SB 0x101 wdata 0x55 with ready low 3 cycles -> request held stable 4 cycles, wstrb=0010; then LW 0x100 hits, rdata=0xDEAD55EF.
REQ-037 LW 0x140 (same index as 0x100, different tag) -> miss, line refilled; later LW 0x100 misses.
REQ-038 Reset asserted in RD_WAIT -> IDLE, mem_req_valid=0; late mem_resp_valid ignored; LW 0x100 misses.
REQ-039 With DCACHE_STATS_EN, sequence of REQ-034 -> stat_misses=1, stat_hits=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Define DCACHE_STATS_EN to build dcache_ctrl with hit/miss counters.
package dcache_pkg;

  localparam int LINES = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = 26;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  // Byte strobes of a store; mask[2] (unsigned) does not affect stores.
  function automatic logic [3:0] store_strb(input logic [2:0] m, input logic [1:0] off);
    case (m[1:0])
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = off[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] m, input logic [31:0] d);
    case (m[1:0])
      2'b00:   store_data = {4{d[7:0]}};
      2'b01:   store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Backing-memory request/response channel between dcache_ctrl and memory.
// A request transfers on a cycle with mem_req_valid=1 and mem_req_ready=1; while valid is high and ready low, all mem_req_* hold steady. A response is a single mem_resp_valid pulse.
interface dcache_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/dcache_load_align.sv
// Load lane select and sign/zero extension of a cached word.
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  mask_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (mask_i)
      MASK_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      MASK_BU: data_o = {24'h0, byte_sel};
      MASK_H:  data_o = {{16{half_sel[15]}}, half_sel};
      MASK_HU: data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, 16 x 1-word, write-through no-write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds stat_hits/stat_misses counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [2:0]    mask,
  output logic [31:0]   rdata,
  output logic          hit,
  output logic          stall,
  output state_t        dbg_state_o,
  dcache_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_misses
`endif
);
  state_t           state_q, state_d;
  logic [31:0]      line_data_q [LINES];
  logic [TAG_W-1:0] line_tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  logic [31:0]      req_addr_q, req_wdata_q;
  logic [3:0]       req_wstrb_q;

  logic [IDX_W-1:0] idx, req_idx;
  logic             line_match, req_match, idle_load, load_hit;
  logic             latch_en, fill_en, upd_en;
  logic [31:0]      aligned;

  assign idx        = addr[5:2];
  assign req_idx    = req_addr_q[5:2];
  assign line_match = valid_q[idx] && (line_tag_q[idx] == addr[31:6]);
  assign req_match  = valid_q[req_idx] && (line_tag_q[req_idx] == req_addr_q[31:6]);
  // A simultaneous read+write is a store, so it never counts as a load.
  assign idle_load  = !reset && (state_q == IDLE) && mem_read && !mem_write;
  assign load_hit   = idle_load && line_match;

  dcache_load_align u_align (
    .word_i (line_data_q[idx]),
    .off_i  (addr[1:0]),
    .mask_i (mask),
    .data_o (aligned)
  );

  assign hit         = load_hit;
  assign rdata       = load_hit ? aligned : 32'h0;
  assign dbg_state_o = state_q;

  assign mem.mem_req_valid = !reset && ((state_q == RD_REQ) || (state_q == WR_REQ));
  assign mem.mem_req_we    = (state_q == WR_REQ);
  assign mem.mem_req_addr  = req_addr_q;
  assign mem.mem_req_wdata = req_wdata_q;
  assign mem.mem_req_wstrb = req_wstrb_q;

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    latch_en = 1'b0;
    fill_en  = 1'b0;
    upd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          state_d  = WR_REQ;
        end else if (mem_read && !line_match) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        stall = 1'b1;
        if (mem.mem_req_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem.mem_resp_valid) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        // The store retires in its acceptance cycle, so stall drops here.
        if (mem.mem_req_ready) begin
          upd_en  = req_match;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d  = IDLE;
      stall    = 1'b0;
      latch_en = 1'b0;
      fill_en  = 1'b0;
      upd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
      req_wstrb_q <= 4'h0;
    end else begin
      state_q <= state_d;
      if (fill_en) valid_q[req_idx] <= 1'b1;
      if (latch_en) begin
        req_addr_q  <= {addr[31:2], 2'b00};
        req_wdata_q <= store_data(mask, wdata);
        req_wstrb_q <= mem_write ? store_strb(mask, addr[1:0]) : 4'h0;
      end
    end
  end

  // Line data and tags survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      line_data_q[req_idx] <= mem.mem_resp_rdata;
      line_tag_q[req_idx]  <= req_addr_q[31:6];
    end else if (upd_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb_q[b]) line_data_q[req_idx][8*b +: 8] <= req_wdata_q[8*b +: 8];
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, misses_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= 32'h0;
      misses_q <= 32'h0;
    end else if (idle_load) begin
      if (line_match) hits_q   <= hits_q + 32'd1;
      else            misses_q <= misses_q + 32'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif
endmodule
